// File: rtl/sync_array_wr_arb.sv
// Round-robin write arbiter for a shared register array that feeds a slow-domain synchronizer.
// Build option SYNC_ARB_PRIO0_EN gives requester 0 fixed absolute priority.
module sync_array_wr_arb #(
    parameter int REQ_N    = 3,
    parameter int ARRAY_W  = 9,
    parameter int DATA_W   = 12,
    parameter int HOLD_CYC = 8,
    parameter int AW       = $clog2(ARRAY_W)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [REQ_N-1:0]                 req_i,
    input  logic [REQ_N-1:0][AW-1:0]         addr_i,
    input  logic [REQ_N-1:0][DATA_W-1:0]     data_i,
    output logic [REQ_N-1:0]                 gnt_o,
    output logic [ARRAY_W-1:0][DATA_W-1:0]   array_o,
    output logic                             busy_o,
    output logic                             err_o
);
    localparam int PW = $clog2(REQ_N);
    localparam int CW = $clog2(HOLD_CYC + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q;
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;

    logic [REQ_N-1:0] req_eff;
    logic             found;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic             upd_ptr;
    logic             addr_bad;

    // Handshake: req_i is a level held with its addr/data until the one-cycle
    // gnt_o pulse; the requester drops it one cycle after seeing gnt_o.  After
    // an error grant the arbiter stays in IDLE, so the still-raised bit is masked.
    always_comb begin
        req_eff = req_i & ~(err_o ? gnt_o : '0);
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        upd_ptr = 1'b1;
`ifdef SYNC_ARB_PRIO0_EN
        if (req_eff[0]) begin
            found   = 1'b1;
            upd_ptr = 1'b0;
        end else begin
            for (int i = 1; i <= REQ_N; i++) begin
                idx = PW'((int'(ptr_q) + i) % REQ_N);
                if (!found && idx != '0 && req_eff[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
`else
        for (int i = 1; i <= REQ_N; i++) begin
            idx = PW'((int'(ptr_q) + i) % REQ_N);
            if (!found && req_eff[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`endif
        addr_bad = (int'(addr_i[win]) >= ARRAY_W);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= PW'(REQ_N - 1);
            cnt_q   <= '0;
            gnt_o   <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            array_o <= '0;
        end else begin
            gnt_o <= '0;
            err_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_o[win] <= 1'b1;
                        if (upd_ptr) ptr_q <= win;
                        if (addr_bad) begin
                            err_o <= 1'b1;
                        end else begin
                            array_o[addr_i[win]] <= data_i[win];
                            state_q <= HOLD;
                            cnt_q   <= CW'(HOLD_CYC - 1);
                            busy_o  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // busy_o covers the grant cycle plus HOLD_CYC-1 more
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sync_array_wr_arb.sv
// Scoreboard bench for sync_array_wr_arb: expected grants are queued when requests are driven.
module tb_sync_array_wr_arb;
    localparam int REQ_N = 3, ARRAY_W = 9, DATA_W = 12, HOLD_CYC = 8, AW = 4;
    localparam int EW = REQ_N + 1 + 16;

    logic                           clk_i = 1'b0;
    logic                           rst_n_i;
    logic [REQ_N-1:0]               req_i;
    logic [REQ_N-1:0][AW-1:0]       addr_i;
    logic [REQ_N-1:0][DATA_W-1:0]   data_i;
    logic [REQ_N-1:0]               gnt_o;
    logic [ARRAY_W-1:0][DATA_W-1:0] array_o;
    logic                           busy_o;
    logic                           err_o;

    sync_array_wr_arb #(
        .REQ_N(REQ_N), .ARRAY_W(ARRAY_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC), .AW(AW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
        .gnt_o(gnt_o), .array_o(array_o), .busy_o(busy_o), .err_o(err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] model_arr[ARRAY_W];
    logic [REQ_N-1:0]  gnt_seen = '0;
    logic [REQ_N-1:0]  drop_prev = '0;
    logic              rearm = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [REQ_N-1:0] g, input logic e, input int at);
        exp_q.push_back({g, e, 16'(at)});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_o; i++) step(1);
        check("idle_timeout", {63'd0, busy_o}, 64'd0);
    endtask

    task automatic check_array(input string tag);
        for (int i = 0; i < ARRAY_W; i++) check(tag, {52'd0, array_o[i]}, {52'd0, model_arr[i]});
    endtask

    // scoreboard: every grant pulse is matched against the head of exp_q
    always @(negedge clk_i) begin
        logic [EW-1:0] item;
        gnt_seen = gnt_o;
        if (err_o && gnt_o == '0) check("err_without_gnt", 64'd1, 64'd0);
        if (gnt_o != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", {61'd0, gnt_o}, 64'd0);
            end else begin
                item = exp_q.pop_front();
                check("gnt", {61'd0, gnt_o}, {61'd0, item[EW-1 -: REQ_N]});
                check("err", {63'd0, err_o}, {63'd0, item[16]});
                check("gnt_cycle", {48'd0, cyc[15:0]}, {48'd0, item[15:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int busy_cnt;
        int first_busy;
        logic [DATA_W-1:0] d0, d1, d2;

        rst_n_i = 1'b0;
        req_i   = '0;
        addr_i  = '0;
        data_i  = '0;
        for (int i = 0; i < ARRAY_W; i++) model_arr[i] = '0;

        // requester driver: drop a request the cycle after its grant, optionally re-raise
        fork
            forever begin
                @(posedge clk_i);
                #2;
                if (rearm) req_i = req_i | drop_prev;
                drop_prev = gnt_seen;
                req_i = req_i & ~gnt_seen;
            end
        join_none

        step(2);
        check("rst_gnt", {61'd0, gnt_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check_array("rst_array");
        rst_n_i = 1'b1;
        step(2);

        // fairness: all three request continuously
        c = cyc;
        rearm = 1'b1;
        for (int k = 0; k < REQ_N; k++) begin
            addr_i[k] = AW'(k);
            data_i[k] = DATA_W'($urandom_range(0, 4095));
            model_arr[k] = data_i[k];
        end
        req_i = 3'b111;
`ifdef SYNC_ARB_PRIO0_EN
        for (int g = 0; g < 4; g++) push_exp(3'b001, 1'b0, c + 1 + 9 * g);
        model_arr[1] = '0;
        model_arr[2] = '0;
`else
        push_exp(3'b001, 1'b0, c + 1);
        push_exp(3'b010, 1'b0, c + 10);
        push_exp(3'b100, 1'b0, c + 19);
        push_exp(3'b001, 1'b0, c + 28);
`endif
        step(29);
        rearm = 1'b0;
        req_i = '0;
        step(1);
        wait_idle();
        check_array("fair_array");

        // reset in the middle of a hold
        c = cyc;
        addr_i[0] = 4'd2;
        data_i[0] = 12'h5A5;
        req_i = 3'b001;
        push_exp(3'b001, 1'b0, c + 1);
        step(3);
        check("pre_rst_entry2", {52'd0, array_o[2]}, 64'h5A5);
        check("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("async_rst_busy", {63'd0, busy_o}, 64'd0);
        check("async_rst_gnt", {61'd0, gnt_o}, 64'd0);
        for (int i = 0; i < ARRAY_W; i++) model_arr[i] = '0;
        check_array("async_rst_array");
        req_i = '0;
        step(2);
        rst_n_i = 1'b1;
        step(1);

        c = cyc;
        addr_i[0] = 4'd0;
        data_i[0] = DATA_W'($urandom_range(0, 4095));
        addr_i[1] = 4'd1;
        data_i[1] = DATA_W'($urandom_range(0, 4095));
        model_arr[0] = data_i[0];
        model_arr[1] = data_i[1];
        req_i = 3'b011;
        push_exp(3'b001, 1'b0, c + 1);
        push_exp(3'b010, 1'b0, c + 10);
        step(11);
        wait_idle();

        // single write, busy exactly HOLD_CYC cycles
        c = cyc;
        addr_i[1] = 4'd4;
        data_i[1] = 12'hABC;
        model_arr[4] = 12'hABC;
        req_i[1] = 1'b1;
        push_exp(3'b010, 1'b0, c + 1);
        busy_cnt = 0;
        first_busy = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (busy_o) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
        end
        check("busy_len", 64'(busy_cnt), 64'(HOLD_CYC));
        check("busy_start", 64'(first_busy), 64'(c + 1));
        check_array("single_array");
        step(1);
        wait_idle();

        // bad address: error grant, no write, no hold, re-request masked
        c = cyc;
        addr_i[2] = 4'd9;
        data_i[2] = 12'hFFF;
        req_i[2] = 1'b1;
        push_exp(3'b100, 1'b1, c + 1);
        step(1);
        check("bad_busy0", {63'd0, busy_o}, 64'd0);
        check_array("bad_array");
        step(1);
        check("bad_busy1", {63'd0, busy_o}, 64'd0);
        addr_i[0] = 4'd4;
        data_i[0] = 12'h3C3;
        model_arr[4] = 12'h3C3;
        req_i[0] = 1'b1;
        push_exp(3'b001, 1'b0, c + 3);

        // request during hold waits for the IDLE arbitration cycle
        step(3);
        check("hold_busy", {63'd0, busy_o}, 64'd1);
        check("hold_entry4", {52'd0, array_o[4]}, 64'h3C3);
        addr_i[0] = 4'd4;
        data_i[0] = 12'h777;
        model_arr[4] = 12'h777;
        req_i[0] = 1'b1;
        push_exp(3'b001, 1'b0, c + 12);
        step(6);
        check("idle_gap_busy", {63'd0, busy_o}, 64'd0);
        check("idle_gap_gnt", {61'd0, gnt_o}, 64'd0);
        step(1);
        check("last_write_wins", {52'd0, array_o[4]}, 64'h777);
        check("rehold_busy", {63'd0, busy_o}, 64'd1);

        // requester 0 joins pending 1 and 2 during hold
        c = cyc;
        d0 = DATA_W'($urandom_range(0, 4095));
        d1 = DATA_W'($urandom_range(0, 4095));
        d2 = DATA_W'($urandom_range(0, 4095));
        step(1);
        addr_i[1] = 4'd6;
        data_i[1] = d1;
        addr_i[2] = 4'd8;
        data_i[2] = d2;
        req_i = 3'b110;
        step(2);
        addr_i[0] = 4'd5;
        data_i[0] = d0;
        req_i[0] = 1'b1;
        model_arr[5] = d0;
        model_arr[6] = d1;
        model_arr[8] = d2;
`ifdef SYNC_ARB_PRIO0_EN
        push_exp(3'b001, 1'b0, c + 9);
        push_exp(3'b010, 1'b0, c + 18);
        push_exp(3'b100, 1'b0, c + 27);
`else
        push_exp(3'b010, 1'b0, c + 9);
        push_exp(3'b100, 1'b0, c + 18);
        push_exp(3'b001, 1'b0, c + 27);
`endif

        for (int i = 0; i < 60 && exp_q.size() > 0; i++) step(1);
        check("drain", 64'(exp_q.size()), 64'd0);
        step(1);
        wait_idle();
        check_array("final_array");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_array_wr_arb.md
Name: sync_array_wr_arb

Overview:
- Arbitrates between REQ_N requesters writing single entries of a shared ARRAY_W x DATA_W register array in one clock domain. Example requesters: time-set, alarm-set and tick logic.
- The array is the source data for a downstream multi-stage synchronizer into another clock domain.
- After every accepted write, the array is frozen for HOLD_CYC cycles so the far-side synchronizer always captures a coherent, settled array.
- Grants use round-robin fairness.

Parameters:
- REQ_N, 3: number of requesters, minimum 2.
- ARRAY_W, 9: number of array entries.
- DATA_W, 12: bits per entry.
- HOLD_CYC, 8: cycles the array is frozen after each write. Legal range ≥1. Sized ≥ (sync depth + 1) x slow/fast clock ratio.
- Derived AW = $clog2(ARRAY_W): entry address width.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_i  in  [REQ_N-1:0]  write request per requester; level, held until granted.
- addr_i  in  [REQ_N-1:0][AW-1:0]  entry index per requester; stable while req_i high.
- data_i  in  [REQ_N-1:0][DATA_W-1:0]  write data per requester; stable while req_i high.
- gnt_o  out  [REQ_N-1:0]  one-hot, one-cycle grant pulse; write accepted.
- array_o  out  [ARRAY_W-1:0][DATA_W-1:0]  registered shared array, feeds the synchronizer.
- busy_o  out  1  high while the array is frozen (HOLD).
- err_o  out  1  one-cycle pulse: granted write had addr ≥ ARRAY_W.

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - array_o = 0, gnt_o = 0, busy_o = 0, err_o = 0.
  - state = IDLE, hold counter = 0.
  - RR pointer = REQ_N-1, so requester 0 wins first.
- FSM states: IDLE, HOLD.
- IDLE with |req_i = 0: stay in IDLE, no outputs change.
- IDLE with |req_i = 1, at edge E:
  - Winner k = first set req_i bit searching from (ptr+1) mod REQ_N upward, wrapping.
  - From E, for the following cycle: gnt_o[k] = 1; ptr = k.
  - If addr_i[k] < ARRAY_W: array_o[addr_i[k]] = data_i[k]; go to HOLD; counter = HOLD_CYC-1; busy_o = 1.
  - If addr_i[k] ≥ ARRAY_W: no write; err_o = 1; stay in IDLE, no hold. Grant still consumes the RR turn.
- HOLD:
  - busy_o = 1; no grants; array_o frozen.
  - Counter decrements each cycle; at 0, the next edge returns to IDLE.
  - busy_o is high exactly HOLD_CYC cycles, starting with the gnt_o cycle.
- Latency:
  - req_i seen in an IDLE cycle → gnt_o and new array_o value one cycle later.
  - Minimum spacing between valid-write grants = HOLD_CYC+1 cycles (one IDLE arbitration cycle after HOLD).
- Requester protocol:
  - Requester drops req_i in the cycle after seeing its gnt_o.
  - The arbiter never re-grants in the gnt_o cycle, because it is in HOLD or, after an error grant, it masks the just-granted bit for one cycle.
- req_i deasserted before grant: request is lost silently; no gnt_o.
- Requests arriving during HOLD wait. All pending requests are arbitrated RR at the first IDLE cycle.
- Unwritten entries retain their value indefinitely.
- Same addr written by successive requesters: last write wins; each write gets its own hold.
- Reset asserted mid-HOLD: immediate return to reset values; the pending hold is abandoned.

Optional Feature:
- Macro: SYNC_ARB_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority. If req_i[0] is high in IDLE, it wins regardless of ptr, and ptr is not updated. Requesters 1..REQ_N-1 share the remaining turns round-robin among themselves.
- Undefined: pure round-robin across all REQ_N requesters, as described in Behaviour.

Test Plan:
- Reset check: drive rst_n_i=0 mid-HOLD after writing array_o[2]=12'h5A5 → array_o all 0, busy_o=0, gnt_o=0 asynchronously. After release, req_i=3'b011 → gnt_o=3'b001 first.
- Single write: req_i[1]=1, addr=4, data=12'hABC → next cycle gnt_o=3'b010 and array_o[4]=12'hABC; busy_o high exactly 8 cycles; other entries unchanged.
- Fairness: req_i=3'b111 held, each requester dropping after its grant and re-requesting → grant order 0,1,2,0, with grant pulses exactly 9 cycles apart.
- Bad address: req_i[2]=1, addr=9 → gnt_o=3'b100 with err_o=1 the same cycle; array_o unchanged; busy_o stays 0; next request is granted 2 cycles later.
- Hold blocking: req_i[0] asserted on the 3rd busy cycle → no grant until busy_o falls; gnt_o[0] appears exactly 1 cycle after the last busy cycle.
- With SYNC_ARB_PRIO0_EN: req_i=3'b110 pending, req_i[0] rises → gnt_o=3'b001 at the next IDLE; without the macro, the RR order yields gnt_o=3'b010 first.
